// File: rtl/tdpram_pkg.sv
// tdpram_pkg: shared types and helpers for the byte-write true dual-port RAM.
//   init_state_e : clear-engine states (IDLE, CLEAR, DONE)
//   nb()         : number of byte lanes in a word
//   cfg_ok()     : parameter legality check used at elaboration
package tdpram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } init_state_e;

  function automatic int nb(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Word must split evenly into lanes and the read pipe supports 1..4 stages.
  function automatic bit cfg_ok(input int data_width, input int byte_width,
                                input int read_latency);
    return ((data_width % byte_width) == 0) &&
           (read_latency >= 1) && (read_latency <= 4);
  endfunction

endpackage

// File: rtl/tdpram_rd_pipe.sv
// tdpram_rd_pipe: LATENCY-deep data+valid shift pipeline for one read port.
//   clk, rstn        : clock, async active-low reset
//   i_valid, i_data  : read request strobe and the word sampled this cycle
//   o_valid, o_data  : strobe and word LATENCY cycles later
// Each stage only loads when its upstream stage is valid, so the final stage
// (and therefore o_data) holds its last valid word between reads.
module tdpram_rd_pipe
  import tdpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_data [LATENCY];
  logic [LATENCY-1:0]    r_valid;

  // Shift valid every cycle; move data only alongside a valid token.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= {LATENCY{1'b0}};
      for (int s = 0; s < LATENCY; s++) begin
        r_data[s] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_valid[0] <= i_valid;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        if (r_valid[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/tdpram_byte_write_init.sv
// tdpram_byte_write_init: single-clock true dual-port RAM, per-byte write
// enables, programmable read latency with valid strobes, and a clear engine
// that writes INIT_VALUE to every word after reset or on request.
//   clk, rstn                     : clock, async active-low reset
//   init_start/init_busy/init_done: sweep request, in-progress flag, done pulse
//   ena/wea/addra/dina            : port A request (read when wea == 0)
//   douta/vlda                    : port A read data and valid strobe
//   enb/web/addrb/dinb/doutb/vldb : same for port B
// Same-address writes: port A owns every lane it enables. A read colliding
// with a write on the other port returns the old word.
module tdpram_byte_write_init
  import tdpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    BYTE_WIDTH    = 8,
  parameter int                    READ_LATENCY  = 2,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = {DATA_WIDTH{1'b0}}
)(
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             init_start,
  output logic                             init_busy,
  output logic                             init_done,
  input  logic                             ena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  output logic [DATA_WIDTH-1:0]            douta,
  output logic                             vlda,
  input  logic                             enb,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  input  logic [DATA_WIDTH-1:0]            dinb,
  output logic [DATA_WIDTH-1:0]            doutb,
  output logic                             vldb
);

  localparam int NB    = nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (!cfg_ok(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY)) begin : g_cfg_err
    $error("tdpram_byte_write_init: illegal DATA_WIDTH/BYTE_WIDTH/READ_LATENCY");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  init_state_e           r_state;
  init_state_e           w_state_nxt;
  logic                  r_boot;      // one-shot: sweep requested by reset release
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_busy;
  logic                  r_done;

  logic w_user_ok;
  logic w_rd_a, w_wr_a, w_rd_b, w_wr_b;

  // User traffic is only accepted in IDLE, and not in the cycle that is about
  // to launch the automatic post-reset sweep.
  assign w_user_ok = (r_state == ST_IDLE) && !r_boot;
  assign w_rd_a    = ena && w_user_ok && (wea == {NB{1'b0}});
  assign w_wr_a    = ena && w_user_ok && (wea != {NB{1'b0}});
  assign w_rd_b    = enb && w_user_ok && (web == {NB{1'b0}});
  assign w_wr_b    = enb && w_user_ok && (web != {NB{1'b0}});

  // Clear-engine next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_boot || init_start) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Clear-engine state, sweep address and registered status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_boot     <= (INIT_ON_RESET != 0);
      r_clr_addr <= {ADDR_WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_boot  <= 1'b0;
      r_busy  <= (w_state_nxt == ST_CLEAR);
      r_done  <= (w_state_nxt == ST_DONE);
      if (r_state == ST_CLEAR) begin
        r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
      end else begin
        r_clr_addr <= {ADDR_WIDTH{1'b0}};
      end
    end
  end

  // Storage writes. Port A lanes are assigned after port B so A wins per lane.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_addr] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_wr_b && web[i]) begin
          r_mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (w_wr_a && wea[i]) begin
          r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // The first pipe stage samples the array in the same edge as any write, so
  // a cross-port read sees the pre-write word.
  tdpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_a (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_rd_a),
    .i_data  (r_mem[addra]),
    .o_valid (vlda),
    .o_data  (douta)
  );

  tdpram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_pipe_b (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (w_rd_b),
    .i_data  (r_mem[addrb]),
    .o_valid (vldb),
    .o_data  (doutb)
  );

  assign init_busy = r_busy;
  assign init_done = r_done;

endmodule

// File: tb/tb_tdpram_byte_write_init.sv
// Directed bench for tdpram_byte_write_init: default build (256 x 32, latency 2,
// clear on reset) plus a small latency-4 build with a non-zero INIT_VALUE.
module tb_tdpram_byte_write_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  // default build
  logic        init_start, init_busy, init_done;
  logic        ena, enb, vlda, vldb;
  logic [3:0]  wea, web;
  logic [7:0]  addra, addrb;
  logic [31:0] dina, dinb, douta, doutb;
  // latency-4 build
  logic        q_init_start, q_init_busy, q_init_done;
  logic        q_ena, q_enb, q_vlda, q_vldb;
  logic [3:0]  q_wea, q_web;
  logic [3:0]  q_addra, q_addrb;
  logic [31:0] q_dina, q_dinb, q_douta, q_doutb;

  int checks = 0;
  int errors = 0;

  tdpram_byte_write_init dut (
    .clk(clk), .rstn(rstn),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .vlda(vlda),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .vldb(vldb)
  );

  tdpram_byte_write_init #(
    .ADDR_WIDTH(4), .READ_LATENCY(4), .INIT_ON_RESET(0), .INIT_VALUE(32'hDEAD_BEEF)
  ) dut4 (
    .clk(clk), .rstn(rstn),
    .init_start(q_init_start), .init_busy(q_init_busy), .init_done(q_init_done),
    .ena(q_ena), .wea(q_wea), .addra(q_addra), .dina(q_dina), .douta(q_douta), .vlda(q_vlda),
    .enb(q_enb), .web(q_web), .addrb(q_addrb), .dinb(q_dinb), .doutb(q_doutb), .vldb(q_vldb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one read on the default build and collect what came back at +2,
  // plus whether the strobe was low at +1, high at +2 and low at +3.
  task automatic read_obs(input bit pb, input logic [7:0] addr,
                          output logic [31:0] dat, output bit vok);
    if (pb) begin enb = 1'b1; web = 4'h0; addrb = addr; end
    else    begin ena = 1'b1; wea = 4'h0; addra = addr; end
    tick;
    ena = 1'b0; enb = 1'b0;
    vok = pb ? (vldb === 1'b0) : (vlda === 1'b0);
    tick;
    vok = vok && (pb ? (vldb === 1'b1) : (vlda === 1'b1));
    dat = pb ? doutb : douta;
    tick;
    vok = vok && (pb ? (vldb === 1'b0) : (vlda === 1'b0));
  endtask

  task automatic wr(input bit pb, input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    if (pb) begin enb = 1'b1; web = be; addrb = addr; dinb = data; end
    else    begin ena = 1'b1; wea = be; addra = addr; dina = data; end
    tick;
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick; tick; tick;
    checks++; if (douta !== 32'h0) begin errors++; $display("FAIL reset_douta: actual=%h required=0", douta); end
    checks++; if (doutb !== 32'h0) begin errors++; $display("FAIL reset_doutb: actual=%h required=0", doutb); end
    checks++; if ({vlda, vldb} !== 2'b00) begin errors++; $display("FAIL reset_vld: actual=%b required=00", {vlda, vldb}); end
    checks++; if ({init_busy, init_done} !== 2'b00) begin errors++; $display("FAIL reset_init: actual=%b required=00", {init_busy, init_done}); end
    checks++; if ({q_vlda, q_vldb, q_init_busy, q_init_done} !== 4'h0) begin errors++; $display("FAIL reset_dut4: actual=%b required=0000", {q_vlda, q_vldb, q_init_busy, q_init_done}); end
  endtask

  task automatic test_boot_sweep;
    int nbusy = 0, ndone = 0, nq = 0;
    bit seq_bad = 1'b0;
    logic prev_busy = 1'b0;
    logic [31:0] d;
    bit v;
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (init_busy === 1'b1) nbusy++;
      if (init_done === 1'b1) begin
        ndone++;
        if (prev_busy !== 1'b1) seq_bad = 1'b1;
      end
      if (q_init_busy === 1'b1 || q_init_done === 1'b1) nq++;
      prev_busy = init_busy;
    end
    checks++; if (nbusy != 256) begin errors++; $display("FAIL boot_busy_cycles: actual=%0d required=256", nbusy); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL boot_done_pulses: actual=%0d required=1", ndone); end
    checks++; if (seq_bad) begin errors++; $display("FAIL boot_done_follows_busy: actual=1 required=0"); end
    checks++; if (nq != 0) begin errors++; $display("FAIL dut4_no_auto_sweep: actual=%0d required=0", nq); end
    read_obs(1'b0, 8'h00, d, v);
    checks++; if (d !== 32'h0 || !v) begin errors++; $display("FAIL boot_read_a_00: actual=%h/%0d required=00000000/1", d, v); end
    read_obs(1'b1, 8'hFF, d, v);
    checks++; if (d !== 32'h0 || !v) begin errors++; $display("FAIL boot_read_b_ff: actual=%h/%0d required=00000000/1", d, v); end
  endtask

  task automatic test_latency4;
    int nbusy = 0, ndone = 0, bad = 0;
    q_init_start = 1'b1;
    tick;
    q_init_start = 1'b0;
    if (q_init_busy === 1'b1) nbusy++;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (q_init_busy === 1'b1) nbusy++;
      if (q_init_done === 1'b1) ndone++;
    end
    checks++; if (nbusy != 16 || ndone != 1) begin errors++; $display("FAIL lat4_sweep: actual=%0d/%0d required=16/1", nbusy, ndone); end
    q_ena = 1'b1; q_wea = 4'h0; q_addra = 4'h3;
    for (int k = 1; k <= 5; k++) begin
      tick;
      q_ena = 1'b0;
      if (k == 4) begin
        checks++;
        if (q_vlda !== 1'b1 || q_douta !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lat4_read_a: actual=%h/%b required=deadbeef/1", q_douta, q_vlda); end
      end else if (q_vlda !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lat4_strobe_timing_a: actual=%0d required=0", bad); end
    q_enb = 1'b1; q_web = 4'b1001; q_addrb = 4'h7; q_dinb = 32'h0102_0304;
    tick;
    q_web = 4'h0; bad = 0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      q_enb = 1'b0;
      if (k == 4) begin
        checks++;
        if (q_vldb !== 1'b1 || q_doutb !== 32'h01AD_BE04) begin errors++; $display("FAIL lat4_read_b: actual=%h/%b required=01adbe04/1", q_doutb, q_vldb); end
      end else if (q_vldb !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lat4_strobe_timing_b: actual=%0d required=0", bad); end
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    bit v;
    wr(1'b0, 8'h10, 32'hAABB_CCDD, 4'b1111);
    read_obs(1'b0, 8'h10, d, v);
    checks++; if (d !== 32'hAABB_CCDD || !v) begin errors++; $display("FAIL full_write: actual=%h/%0d required=aabbccdd/1", d, v); end
    wr(1'b0, 8'h10, 32'h1122_3344, 4'b0010);
    checks++; if (vlda !== 1'b0 || douta !== 32'hAABB_CCDD) begin errors++; $display("FAIL write_no_change_1: actual=%h/%b required=aabbccdd/0", douta, vlda); end
    tick;
    checks++; if (vlda !== 1'b0 || douta !== 32'hAABB_CCDD) begin errors++; $display("FAIL write_no_change_2: actual=%h/%b required=aabbccdd/0", douta, vlda); end
    read_obs(1'b1, 8'h10, d, v);
    checks++; if (d !== 32'hAABB_33DD || !v) begin errors++; $display("FAIL byte_write: actual=%h/%0d required=aabb33dd/1", d, v); end
  endtask

  task automatic test_collision_write;
    logic [31:0] d;
    bit v;
    ena = 1'b1; wea = 4'b0011; addra = 8'h20; dina = 32'h1111_1111;
    enb = 1'b1; web = 4'b0110; addrb = 8'h20; dinb = 32'h2222_2222;
    tick;
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    read_obs(1'b0, 8'h20, d, v);
    checks++; if (d !== 32'h0022_1111 || !v) begin errors++; $display("FAIL ww_collision: actual=%h/%0d required=00221111/1", d, v); end
  endtask

  task automatic test_read_first;
    logic [31:0] d;
    bit v;
    wr(1'b0, 8'h30, 32'h0000_0005, 4'b1111);
    ena = 1'b1; wea = 4'h0; addra = 8'h30;
    enb = 1'b1; web = 4'hF; addrb = 8'h30; dinb = 32'h0000_0009;
    tick;
    ena = 1'b0; enb = 1'b0; web = 4'h0;
    tick;
    checks++; if (vlda !== 1'b1 || douta !== 32'h5 || vldb !== 1'b0) begin errors++; $display("FAIL read_first: actual=%h/%b/%b required=00000005/1/0", douta, vlda, vldb); end
    tick;
    read_obs(1'b0, 8'h30, d, v);
    checks++; if (d !== 32'h9 || !v) begin errors++; $display("FAIL after_rw_collision: actual=%h/%0d required=00000009/1", d, v); end
    ena = 1'b1; addra = 8'h30; enb = 1'b1; addrb = 8'h30;
    tick;
    ena = 1'b0; enb = 1'b0;
    tick;
    checks++; if ({vlda, vldb} !== 2'b11 || douta !== 32'h9 || doutb !== 32'h9) begin errors++; $display("FAIL rr_same_addr: actual=%h/%h/%b required=9/9/11", douta, doutb, {vlda, vldb}); end
    tick;
  endtask

  task automatic test_back_to_back;
    ena = 1'b1; wea = 4'h0; addra = 8'h10;
    tick;
    addra = 8'h20;
    tick;
    ena = 1'b0;
    checks++; if (vlda !== 1'b1 || douta !== 32'hAABB_33DD) begin errors++; $display("FAIL b2b_first: actual=%h/%b required=aabb33dd/1", douta, vlda); end
    tick;
    checks++; if (vlda !== 1'b1 || douta !== 32'h0022_1111) begin errors++; $display("FAIL b2b_second: actual=%h/%b required=00221111/1", douta, vlda); end
    tick;
    checks++; if (vlda !== 1'b0 || douta !== 32'h0022_1111) begin errors++; $display("FAIL b2b_hold: actual=%h/%b required=00221111/0", douta, vlda); end
  endtask

  task automatic test_init_request;
    int nbusy = 0, ndone = 0, nvld = 0;
    logic [31:0] d;
    bit v;
    ena = 1'b1; wea = 4'h0; addra = 8'h30;
    tick;
    ena = 1'b0; init_start = 1'b1;
    tick;
    init_start = 1'b0;
    checks++; if (vlda !== 1'b1 || douta !== 32'h9 || init_busy !== 1'b1) begin errors++; $display("FAIL inflight_read: actual=%h/%b/%b required=9/1/1", douta, vlda, init_busy); end
    if (init_busy === 1'b1) nbusy++;
    ena = 1'b1; wea = 4'hF; addra = 8'h05; dina = 32'hCAFE_F00D;
    enb = 1'b1; web = 4'h0; addrb = 8'h30;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (init_busy === 1'b1) nbusy++;
      if (vlda === 1'b1 || vldb === 1'b1) nvld++;
      init_start = (i == 99) || (init_done === 1'b1);
      if (init_done === 1'b1) begin
        ndone++;
        ena = 1'b0; enb = 1'b0; wea = 4'h0;
      end
    end
    init_start = 1'b0; ena = 1'b0; enb = 1'b0; wea = 4'h0;
    checks++; if (nbusy != 256) begin errors++; $display("FAIL req_busy_cycles: actual=%0d required=256", nbusy); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL req_done_pulses: actual=%0d required=1", ndone); end
    checks++; if (nvld != 0) begin errors++; $display("FAIL masked_reads: actual=%0d required=0", nvld); end
    read_obs(1'b0, 8'h05, d, v);
    checks++; if (d !== 32'h0 || !v) begin errors++; $display("FAIL masked_write: actual=%h/%0d required=00000000/1", d, v); end
    read_obs(1'b1, 8'h30, d, v);
    checks++; if (d !== 32'h0 || !v) begin errors++; $display("FAIL req_cleared: actual=%h/%0d required=00000000/1", d, v); end
  endtask

  task automatic test_reset_mid_sweep;
    int nbusy = 0, ndone = 0, nbad = 0, nstr = 0;
    logic [31:0] d;
    bit v;
    wr(1'b0, 8'hC8, 32'h1234_5678, 4'hF);
    wr(1'b1, 8'h03, 32'h0BAD_F00D, 4'hF);
    read_obs(1'b0, 8'hC8, d, v);
    checks++; if (d !== 32'h1234_5678 || !v) begin errors++; $display("FAIL pre_reset_a: actual=%h/%0d required=12345678/1", d, v); end
    read_obs(1'b1, 8'h03, d, v);
    checks++; if (d !== 32'h0BAD_F00D || !v) begin errors++; $display("FAIL pre_reset_b: actual=%h/%0d required=0badf00d/1", d, v); end
    init_start = 1'b1;
    tick;
    init_start = 1'b0;
    for (int i = 1; i < 100; i++) tick;
    rstn = 1'b0;
    #1;
    checks++; if (douta !== 32'h0 || doutb !== 32'h0) begin errors++; $display("FAIL midrst_dout: actual=%h/%h required=0/0", douta, doutb); end
    checks++; if ({vlda, vldb, init_busy, init_done} !== 4'h0) begin errors++; $display("FAIL midrst_flags: actual=%b required=0000", {vlda, vldb, init_busy, init_done}); end
    tick; tick;
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (init_busy === 1'b1) nbusy++;
      if (init_done === 1'b1) ndone++;
    end
    checks++; if (nbusy != 256 || ndone != 1) begin errors++; $display("FAIL resweep: actual=%0d/%0d required=256/1", nbusy, ndone); end
    for (int i = 0; i < 258; i++) begin
      ena = (i < 256); wea = 4'h0; addra = 8'(i);
      tick;
      if (i >= 1) begin
        if (vlda === 1'b1) nstr++;
        if (i <= 256 && (vlda !== 1'b1 || douta !== 32'h0)) nbad++;
      end
    end
    ena = 1'b0;
    checks++; if (nbad != 0 || nstr != 256) begin errors++; $display("FAIL readback_all: actual=%0d bad/%0d strobes required=0/256", nbad, nstr); end
  endtask

  initial begin
    rstn = 1'b0;
    init_start = 1'b0; ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    addra = 8'h0; addrb = 8'h0; dina = 32'h0; dinb = 32'h0;
    q_init_start = 1'b0; q_ena = 1'b0; q_enb = 1'b0; q_wea = 4'h0; q_web = 4'h0;
    q_addra = 4'h0; q_addrb = 4'h0; q_dina = 32'h0; q_dinb = 32'h0;
    test_reset;
    test_boot_sweep;
    test_latency4;
    test_byte_write;
    test_collision_write;
    test_read_first;
    test_back_to_back;
    test_init_request;
    test_reset_mid_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
